fifo_status: RTL

//  FIFO occupancy/status generator sitting between the write- and read-pointer stages.

---
 rtl/fifo_status.sv | 69 ++++++
 1 files changed

// File: rtl/fifo_status.sv
// rtl/fifo_status.sv - FIFO occupancy, full/empty, watermarks, sticky errors and high-water mark
module fifo_status #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH:0]   wptr,
    input  logic [ADDR_WIDTH:0]   rptr,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic                  clr_err,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   high_water
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] AF_L = LW'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_L = LW'(AE_THRESH);

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_chk
        $error("fifo_status: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_ae_chk
        $error("fifo_status: AE_THRESH must be in 0..DEPTH-1");
    end

    // Modular subtraction stays correct across the wrap-bit toggle.
    assign fifo_level = wptr - rptr;
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                        (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            high_water   <= '0;
        end else begin
            almost_full  <= (fifo_level >= AF_L);
            almost_empty <= (fifo_level <= AE_L);

            // A set condition in the same cycle as clr_err wins.
            if (i_we && fifo_full)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;

            if (i_re && fifo_empty)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;

            if (clr_err || (fifo_level > high_water))
                high_water <= fifo_level;
        end
    end

endmodule
